// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage: valid/ready handshake with a two-entry skid buffer
// (main + skid register), flush and NOP-bubble insertion on the output.
// in_ready comes straight from a flop, so there is no combinational path from
// decode's out_ready back to fetch.
// Optional performance counters are enabled by defining IF_ID_SKID_PERF_EN.
module if_id_skid_stage #(
   parameter int XLEN = 32,
   parameter int ILEN = 32,
   parameter logic [ILEN-1:0] NOP_INSN = ILEN'(32'h00000013)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc4,
   input  logic [ILEN-1:0] in_insn,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc4,
   output logic [ILEN-1:0] out_insn
`ifdef IF_ID_SKID_PERF_EN
   ,
   output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_bubble_cnt,
   output logic [31:0]     perf_flush_cnt
`endif
);

   logic            main_valid_q, main_valid_d;
   logic [XLEN-1:0] main_pc4_q, main_pc4_d;
   logic [ILEN-1:0] main_insn_q, main_insn_d;
   logic            skid_valid_q, skid_valid_d;
   logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
   logic [ILEN-1:0] skid_insn_q, skid_insn_d;
   logic            in_ready_q, in_ready_d;
   logic            acc;
   logic            con;

   assign acc = in_valid && in_ready_q;
   assign con = main_valid_q && out_ready;

   // Next-state of the two entries by occupancy; flush wipes both and drops any
   // entry accepted in the same cycle. Skid is only ever filled from state 1.
   always_comb begin
      main_valid_d = main_valid_q;
      main_pc4_d   = main_pc4_q;
      main_insn_d  = main_insn_q;
      skid_valid_d = skid_valid_q;
      skid_pc4_d   = skid_pc4_q;
      skid_insn_d  = skid_insn_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         case ({main_valid_q, skid_valid_q})
            2'b00: begin
               if (acc) begin
                  main_valid_d = 1'b1;
                  main_pc4_d   = in_pc4;
                  main_insn_d  = in_insn;
               end
            end
            2'b10: begin
               if (acc && con) begin
                  main_pc4_d  = in_pc4;
                  main_insn_d = in_insn;
               end else if (acc) begin
                  skid_valid_d = 1'b1;
                  skid_pc4_d   = in_pc4;
                  skid_insn_d  = in_insn;
               end else if (con) begin
                  main_valid_d = 1'b0;
               end
            end
            2'b11: begin
               if (con) begin
                  main_pc4_d   = skid_pc4_q;
                  main_insn_d  = skid_insn_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: begin
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
            end
         endcase
      end
      in_ready_d = !skid_valid_d;
   end

   // Register the entries and the ready flag; reset empties the stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_pc4_q   <= '0;
         main_insn_q  <= NOP_INSN;
         skid_valid_q <= 1'b0;
         skid_pc4_q   <= '0;
         skid_insn_q  <= NOP_INSN;
         in_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_pc4_q   <= main_pc4_d;
         main_insn_q  <= main_insn_d;
         skid_valid_q <= skid_valid_d;
         skid_pc4_q   <= skid_pc4_d;
         skid_insn_q  <= skid_insn_d;
         in_ready_q   <= in_ready_d;
      end
   end

   // Present a NOP bubble with zero PC+4 whenever nothing valid is held.
   always_comb begin
      out_valid = main_valid_q;
      in_ready  = in_ready_q;
      out_pc4   = main_valid_q ? main_pc4_q : '0;
      out_insn  = main_valid_q ? main_insn_q : NOP_INSN;
   end

`ifdef IF_ID_SKID_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // Saturating event counters; only reset clears them, flush does not.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (!main_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF))
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt  = stall_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
   assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Testbench for if_id_skid_stage: directed stimulus with a scoreboard queue
// filled by the driver and drained by an independent output monitor.
module tb_if_id_skid_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc4;
   logic [31:0] in_insn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc4;
   logic [31:0] out_insn;
`ifdef IF_ID_SKID_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_bubble_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   logic [63:0] exp_q[$];
   logic [63:0] mon_head;
   int          checks = 0;
   int          errors = 0;
   int          pop_count = 0;
   int          pops_before;

   if_id_skid_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc4    (in_pc4),
      .in_insn   (in_insn),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc4   (out_pc4),
      .out_insn  (out_insn)
`ifdef IF_ID_SKID_PERF_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_bubble_cnt (perf_bubble_cnt),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs (just after a rising edge), record the entry
   // in the scoreboard if it is expected to be accepted, then advance.
   task automatic applyStimulus(input logic iv, input logic [31:0] pc4, input logic [31:0] insn,
                                input logic ordy, input logic fl, input logic expect_acc);
      in_valid  = iv;
      in_pc4    = pc4;
      in_insn   = insn;
      out_ready = ordy;
      flush     = fl;
      if (expect_acc) exp_q.push_back({pc4, insn});
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      flush = 1'b0;
   endtask

   // Monitor: on the falling edge compare the presented entry with the head of
   // the scoreboard, pop it when decode consumes, and check bubbles.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
               mon_head = exp_q[0];
               checkOutput("out_pc4", out_pc4, mon_head[63:32]);
               checkOutput("out_insn", out_insn, mon_head[31:0]);
               if (out_ready) begin
                  mon_head = exp_q.pop_front();
                  pop_count++;
               end
            end
         end else begin
            checkOutput("bubble_insn", out_insn, NOP);
            checkOutput("bubble_pc4", out_pc4, 32'd0);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b1;
      in_pc4    = 32'hDEAD0000;
      in_insn   = 32'hFFFFFFFF;
      out_ready = 1'b0;

      // Reset held for two cycles with in_valid asserted.
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst_out_insn", out_insn, NOP);
      checkOutput("rst_out_pc4", out_pc4, 32'd0);
      checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef IF_ID_SKID_PERF_EN
      checkOutput("rst_perf_stall", perf_stall_cnt, 32'd0);
      checkOutput("rst_perf_bubble", perf_bubble_cnt, 32'd0);
      checkOutput("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif

      // Streaming with decode always ready.
      applyStimulus(1'b1, 32'h4, 32'h00500093, 1'b1, 1'b0, 1'b1);
      checkOutput("stream_valid_a", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_ready_a", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'h8, 32'h00A00113, 1'b1, 1'b0, 1'b1);
      checkOutput("stream_valid_b", {31'd0, out_valid}, 32'd1);
      checkOutput("stream_ready_b", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("stream_drained", {31'd0, out_valid}, 32'd0);

      // Stall: fill main and skid, then hold decode off for three cycles.
      applyStimulus(1'b1, 32'h10, 32'h00500093, 1'b0, 1'b0, 1'b1);
      checkOutput("stall_ready_1", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b1, 32'h14, 32'h00A00113, 1'b0, 1'b0, 1'b1);
      checkOutput("stall_ready_full", {31'd0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h99, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
         checkOutput("stall_hold_insn", out_insn, 32'h00500093);
         checkOutput("stall_hold_ready", {31'd0, in_ready}, 32'd0);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_second_insn", out_insn, 32'h00A00113);
      checkOutput("stall_ready_back", {31'd0, in_ready}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_drained", {31'd0, out_valid}, 32'd0);

      // Flush while full with a new entry offered.
      applyStimulus(1'b1, 32'h20, 32'h00100093, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h24, 32'h00200093, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h28, 32'h00300093, 1'b0, 1'b1, 1'b0);
      checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("flush_insn", out_insn, NOP);
      checkOutput("flush_pc4", out_pc4, 32'd0);
      checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);

      // Flush in state 1 with accept and consume in the same cycle.
      applyStimulus(1'b1, 32'h30, 32'h00400093, 1'b0, 1'b0, 1'b1);
      pops_before = pop_count;
      applyStimulus(1'b1, 32'h34, 32'h00600093, 1'b1, 1'b1, 1'b0);
      checkOutput("flush_con_popped", pop_count - pops_before, 32'd1);
      checkOutput("flush_con_valid", {31'd0, out_valid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("flush_quiet", {31'd0, out_valid}, 32'd0);

      // Eight back-to-back entries with accept and consume every cycle.
      pops_before = pop_count;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(4 * i), {12'(i + 1), 20'h00093}, 1'b1, 1'b0, 1'b1);
         checkOutput("b2b_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("b2b_ready", {31'd0, in_ready}, 32'd1);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("b2b_count", pop_count - pops_before, 32'd8);
      checkOutput("b2b_drained", {31'd0, out_valid}, 32'd0);
      checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

`ifdef IF_ID_SKID_PERF_EN
      // Counters: 1 bubble, 3 stalls, 1 flush (consuming), 2 idle bubbles.
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("perf_rst_stall", perf_stall_cnt, 32'd0);
      checkOutput("perf_rst_bubble", perf_bubble_cnt, 32'd0);
      checkOutput("perf_rst_flush", perf_flush_cnt, 32'd0);
      applyStimulus(1'b1, 32'h200, 32'h00700093, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      checkOutput("perf_stall", perf_stall_cnt, 32'd3);
      checkOutput("perf_flush", perf_flush_cnt, 32'd1);
      checkOutput("perf_bubble", perf_bubble_cnt, 32'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("perf_clr_stall", perf_stall_cnt, 32'd0);
      checkOutput("perf_clr_bubble", perf_bubble_cnt, 32'd0);
      checkOutput("perf_clr_flush", perf_flush_cnt, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
